beta_dmem_responder: RTL and testbench
======================================

# beta_dmem_responder

Data-memory responder for the beta core: the target end of the execution stage's data-memory ready/valid protocol. It accepts one load or store request at a time from the exe-stage load/store unit, handshakes with `dmem_rdy_o`, inserts a programmable number of wait states, then returns read data or a write acknowledge with `dmem_vld_o`. It sits between the execution stage and a word-organised on-chip data RAM.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in the RAM; power of two.
- `LATENCY`, 1: wait cycles between the ready pulse and the valid pulse; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH*4.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `dmem_req_i` in 1: request present; held by the initiator until `dmem_rdy_o` is seen.
- `dmem_op_i` in 1: MEM_LOAD_OP (0) or MEM_STORE_OP (1).
- `dmem_size_i` in 2: MEM_SIZE_WORD/HALF/BYTE; 2'b11 is illegal.
- `dmem_addr_i` in 32: byte address.
- `dmem_wdata_i` in 32: store data, right-aligned (the byte or half in the LSBs).
- `dmem_rdy_o` out 1: one-cycle request-accepted pulse.
- `dmem_vld_o` out 1: one-cycle response pulse.
- `dmem_rdata_o` out 32: load data, right-aligned and zero-extended; 0 for stores and errors.
- `dmem_err_o` out 1: qualifies `dmem_vld_o`; access was misaligned, out of range or had an illegal size.

## Operation
- FSM states: RSP_IDLE, RSP_ACK, RSP_WAIT, RSP_RESP.
  - RSP_IDLE, `dmem_req_i`=1: latch op/size/addr/wdata and go to RSP_ACK.
  - RSP_ACK: `dmem_rdy_o`=1; go to RSP_WAIT if LATENCY>0, else RSP_RESP. Load the wait counter with LATENCY-1.
  - RSP_WAIT: decrement the counter; at 0 go to RSP_RESP.
  - RSP_RESP: `dmem_vld_o`=1 with data and err; go to RSP_IDLE.
- Error check on the latched request:
  - half with addr[0]≠0, or word with addr[1:0]≠0;
  - size 2'b11;
  - (addr−BASE_ADDR) ≥ DEPTH*4.
  - On error: no RAM write, `dmem_rdata_o`=0, `dmem_err_o`=1.
- Stores:
  - Byte enables: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
  - wdata is replicated into lanes (byte ×4, half ×2).
  - The RAM write is issued in RSP_ACK and commits on the edge leaving RSP_ACK.
- Loads:
  - RAM read is issued in RSP_ACK; the word is registered and held.
  - In RSP_RESP, shift the word right by 8*addr[1:0], then mask to 8, 16 or 32 bits.
  - No sign extension; the exe stage applies it.
- Ignored inputs: `dmem_req_i` is ignored outside RSP_IDLE, and request inputs are sampled only on the IDLE→ACK edge.
- RAM contents are not reset.

## Timing
- Reset values: all outputs 0, state RSP_IDLE, counter 0. Reset in any state aborts the transaction with no response.
  - A store whose ACK edge has not yet occurred is not written.
  - A store already committed stays written.
- Handshake cycles:
  - Request seen at edge N.
  - `dmem_rdy_o` high in cycle N+1.
  - `dmem_vld_o` high in cycle N+2+LATENCY.
  - Next request accepted at the earliest at edge N+3+LATENCY.
- Throughput: one transaction per LATENCY+3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- The initiator must sample `dmem_vld_o` in its single high cycle; there is no back-pressure on the response.

## Structure
- Add to `beta_exe_stage_pkg`:
  - responder state constants RSP_IDLE/ACK/WAIT/RESP (2 bits), with `rsp_fsm_bsize`=2;
  - a `dmem_req_t` struct for op/size/addr/wdata.
- Reuse MEM_SIZE_* and MEM_*_OP from the package.
- One sub-module, `beta_dmem_ram`: synchronous single-port, DEPTH×32, 4-bit byte-enable write, registered read.

## Test plan
- LATENCY=1, store word 32'hDEADBEEF at 0x10, then load word at 0x10:
  - rdy one cycle after req, vld three cycles after req;
  - rdata=32'hDEADBEEF, err=0.
- Store byte 8'hA5 at 0x13 over word 0, then load word at 0x10:
  - rdata=32'hA5ADBEEF.
  - Load half at 0x12 → 32'h0000A5AD.
- Load half at 0x11:
  - vld=1, err=1, rdata=0.
  - Then store word at 0x11, err=1; a following load of 0x10 is unchanged.
- Address DEPTH*4, store and load both:
  - err=1, memory untouched.
  - Size 2'b11 → err=1.
- LATENCY=0 and LATENCY=15:
  - vld at N+2 and N+17 respectively.
  - Back-to-back requests with req held high: next rdy exactly LATENCY+3 cycles after the previous one.
- Reset mid-operation:
  - Assert rst_i during RSP_WAIT of a store: outputs drop to 0 immediately, no vld; the data is written, since the ACK edge has passed.
  - Assert rst_i during RSP_ACK: no write occurs.

Source files
------------

// File: rtl/beta_exe_stage_pkg.sv
// beta_exe_stage_pkg
// Shared definitions for the beta execution stage and its data-memory
// responder: memory operation / access size encodings, the responder
// state encoding, the latched request record, and small helpers that
// turn an access size plus byte offset into byte-lane information.
// No ports (package).

package beta_exe_stage_pkg;

   // Memory operation encoding as driven by the load/store unit.
   localparam logic MEM_LOAD_OP  = 1'b0;
   localparam logic MEM_STORE_OP = 1'b1;

   // Access size encoding; 2'b11 has no meaning and is flagged as an error.
   localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

   // Data-memory responder state encoding.
   localparam int rsp_fsm_bsize = 2;

   typedef enum logic [rsp_fsm_bsize-1:0] {
      RSP_IDLE = 2'b00,
      RSP_ACK  = 2'b01,
      RSP_WAIT = 2'b10,
      RSP_RESP = 2'b11
   } rspState_t;

   // Everything the responder needs to remember about an accepted request.
   typedef struct packed {
      logic        op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   // Byte lanes touched by an access of the given size at the given offset
   // within the word.  An illegal size touches nothing.
   function automatic logic [3:0] byteEnable(input logic [1:0] size,
                                             input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         MEM_SIZE_BYTE: be = 4'b0001 << offset;
         MEM_SIZE_HALF: be = 4'b0011 << offset;
         MEM_SIZE_WORD: be = 4'b1111;
         default:       be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data arrives right-aligned; copying it into every lane lets the
   // byte enables alone pick the destination lane.
   function automatic logic [31:0] laneReplicate(input logic [1:0] size,
                                                 input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         MEM_SIZE_BYTE: lanes = {4{wdata[7:0]}};
         MEM_SIZE_HALF: lanes = {2{wdata[15:0]}};
         default:       lanes = wdata;
      endcase
      return lanes;
   endfunction

   // Move the addressed byte/half down to bit 0 and zero the rest.  Sign
   // extension is left to the execution stage.
   function automatic logic [31:0] laneExtract(input logic [1:0] size,
                                               input logic [1:0] offset,
                                               input logic [31:0] word);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = word >> {offset, 3'b000};
      case (size)
         MEM_SIZE_BYTE: result = {24'h000000, shifted[7:0]};
         MEM_SIZE_HALF: result = {16'h0000, shifted[15:0]};
         default:       result = shifted;
      endcase
      return result;
   endfunction

   // Halves must sit on even addresses, words on multiples of four.
   function automatic logic isMisaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
      logic bad;
      case (size)
         MEM_SIZE_HALF: bad = offset[0];
         MEM_SIZE_WORD: bad = |offset;
         default:       bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/beta_dmem_ram.sv
// beta_dmem_ram
// Synchronous single-port word RAM, DEPTH x 32, with per-byte write
// enables and a registered read port.  The read register only loads when
// a read is issued, so the last word read stays on rdata_o until the next
// read.  Contents are never reset.
//
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write strobe, qualified by be_i
//   re_i     : read strobe, loads rdata_o on the next edge
//   addr_i   : word index
//   be_i     : byte-lane write enables
//   wdata_i  : lane-aligned write data
//   rdata_o  : registered read data

module beta_dmem_ram #(
   parameter int DEPTH = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] memArray [DEPTH];

   // Byte-lane writes and the registered read share the one port; the
   // responder never asks for both in the same cycle, and because the read
   // register holds its value the responder can pick the word up any number
   // of wait states later.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               memArray[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_o <= memArray[addr_i];
      end
   end

endmodule

// File: rtl/beta_dmem_responder.sv
// beta_dmem_responder
// Target end of the execution stage's data-memory ready/valid protocol.
// Accepts one load or store at a time, pulses dmem_rdy_o the cycle after
// the request is taken, waits LATENCY cycles, then pulses dmem_vld_o with
// right-aligned zero-extended load data (or 0) and an error flag for
// misaligned, out-of-range or illegal-size accesses.
//
// Ports:
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous active-high reset
//   dmem_req_i    : request present, held until dmem_rdy_o
//   dmem_op_i     : MEM_LOAD_OP / MEM_STORE_OP
//   dmem_size_i   : MEM_SIZE_WORD / HALF / BYTE
//   dmem_addr_i   : byte address
//   dmem_wdata_i  : right-aligned store data
//   dmem_rdy_o    : one-cycle request-accepted pulse
//   dmem_vld_o    : one-cycle response pulse
//   dmem_rdata_o  : load data, 0 for stores and errors
//   dmem_err_o    : error qualifier for dmem_vld_o

module beta_dmem_responder
   import beta_exe_stage_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        dmem_req_i,
   input  logic        dmem_op_i,
   input  logic [1:0]  dmem_size_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_wdata_i,
   output logic        dmem_rdy_o,
   output logic        dmem_vld_o,
   output logic [31:0] dmem_rdata_o,
   output logic        dmem_err_o
);

   localparam int          ADDR_W      = $clog2(DEPTH);
   localparam logic [31:0] RANGE_BYTES = 32'(DEPTH * 4);
   localparam logic [3:0]  WAIT_INIT   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   rspState_t   state;
   dmem_req_t   latchedReq;
   logic [3:0]  waitCount;
   logic        rdyReg;
   logic        vldReg;
   logic        errReg;

   logic [31:0] addrOffset;
   logic        outOfRange;
   logic        sizeIllegal;
   logic        reqErr;
   logic        ramWrite;
   logic        ramRead;
   logic [3:0]  ramBe;
   logic [31:0] ramWdata;
   logic [31:0] ramRdata;

   // Classify the latched request.  The range test works on the offset from
   // BASE_ADDR so addresses below the base wrap to huge offsets and fail too.
   // Everything here depends only on registered state, so none of it forms a
   // path from the request inputs to the outputs.
   always_comb begin
      addrOffset  = latchedReq.addr - BASE_ADDR;
      outOfRange  = (addrOffset >= RANGE_BYTES);
      sizeIllegal = (latchedReq.size == 2'b11);
      reqErr      = sizeIllegal || outOfRange ||
                    isMisaligned(latchedReq.size, latchedReq.addr[1:0]);
   end

   // The RAM is touched only in RSP_ACK and only for clean requests.  Because
   // the strobes are decoded from state, an asynchronous reset during ACK
   // kills the write before the edge that would commit it.
   always_comb begin
      ramWrite = (state == RSP_ACK) && (latchedReq.op == MEM_STORE_OP) && !reqErr;
      ramRead  = (state == RSP_ACK) && (latchedReq.op == MEM_LOAD_OP)  && !reqErr;
      ramBe    = byteEnable(latchedReq.size, latchedReq.addr[1:0]);
      ramWdata = laneReplicate(latchedReq.size, latchedReq.wdata);
   end

   // BASE_ADDR is aligned to the RAM size, so the word index can come
   // straight from the low address bits without subtracting the base.
   beta_dmem_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ramWrite),
      .re_i    (ramRead),
      .addr_i  (latchedReq.addr[ADDR_W+1:2]),
      .be_i    (ramBe),
      .wdata_i (ramWdata),
      .rdata_o (ramRdata)
   );

   // Handshake FSM.  Requests are only sampled in RSP_IDLE; the request is
   // captured on that same edge and held until the next one is accepted, so
   // the initiator is free to change its inputs once it has seen rdy.  The
   // rdy/vld/err pulses are registered alongside the state transitions that
   // produce them.  Every pass through IDLE, ACK and RESP costs one cycle
   // each and WAIT costs LATENCY cycles, giving the LATENCY+3 cadence.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= RSP_IDLE;
         latchedReq <= '0;
         waitCount  <= 4'd0;
         rdyReg     <= 1'b0;
         vldReg     <= 1'b0;
         errReg     <= 1'b0;
      end else begin
         rdyReg <= 1'b0;
         vldReg <= 1'b0;
         errReg <= 1'b0;
         case (state)
            RSP_IDLE: begin
               if (dmem_req_i) begin
                  latchedReq.op    <= dmem_op_i;
                  latchedReq.size  <= dmem_size_i;
                  latchedReq.addr  <= dmem_addr_i;
                  latchedReq.wdata <= dmem_wdata_i;
                  rdyReg           <= 1'b1;
                  state            <= RSP_ACK;
               end
            end
            RSP_ACK: begin
               waitCount <= WAIT_INIT;
               if (LATENCY > 0) begin
                  state <= RSP_WAIT;
               end else begin
                  vldReg <= 1'b1;
                  errReg <= reqErr;
                  state  <= RSP_RESP;
               end
            end
            RSP_WAIT: begin
               if (waitCount == 4'd0) begin
                  vldReg <= 1'b1;
                  errReg <= reqErr;
                  state  <= RSP_RESP;
               end else begin
                  waitCount <= waitCount - 4'd1;
               end
            end
            RSP_RESP: begin
               state <= RSP_IDLE;
            end
            default: begin
               state <= RSP_IDLE;
            end
         endcase
      end
   end

   // Load data is aligned from the held RAM word during the response cycle.
   // With LATENCY 0 the RAM word lands on the same edge that enters RESP,
   // which is why this is decoded rather than registered with vld.
   always_comb begin
      dmem_rdy_o   = rdyReg;
      dmem_vld_o   = vldReg;
      dmem_err_o   = errReg;
      dmem_rdata_o = '0;
      if (vldReg && !errReg && (latchedReq.op == MEM_LOAD_OP)) begin
         dmem_rdata_o = laneExtract(latchedReq.size, latchedReq.addr[1:0], ramRdata);
      end
   end

endmodule

// File: tb/tb_beta_dmem_responder.sv
// tb_beta_dmem_responder
// Drives three responders (LATENCY 1, 0 and 15) that share clock, reset
// and request fields but have separate request strobes.  Expected data
// comes from a byte-addressed memory model per responder; expected timing
// comes from the LATENCY+2 / LATENCY+3 handshake rules.

module tb_beta_dmem_responder;
   import beta_exe_stage_pkg::*;

   localparam int DEPTH   = 256;
   localparam int NUM_DUT = 3;
   localparam int LAT0    = 1;
   localparam int LAT1    = 0;
   localparam int LAT2    = 15;

   logic                 clk;
   logic                 rst;
   logic [NUM_DUT-1:0]   req;
   logic                 op;
   logic [1:0]           size;
   logic [31:0]          addr;
   logic [31:0]          wdata;
   logic [NUM_DUT-1:0]   rdy;
   logic [NUM_DUT-1:0]   vld;
   logic [NUM_DUT-1:0]   err;
   logic [31:0]          rdata [NUM_DUT];

   logic [7:0]           modelBytes [NUM_DUT][DEPTH*4];
   int                   numCompared;
   int                   numMismatched;

   beta_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0), .BASE_ADDR(32'h0)) dut0 (
      .clk_i(clk), .rst_i(rst), .dmem_req_i(req[0]), .dmem_op_i(op),
      .dmem_size_i(size), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
      .dmem_rdy_o(rdy[0]), .dmem_vld_o(vld[0]), .dmem_rdata_o(rdata[0]), .dmem_err_o(err[0]));

   beta_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1), .BASE_ADDR(32'h0)) dut1 (
      .clk_i(clk), .rst_i(rst), .dmem_req_i(req[1]), .dmem_op_i(op),
      .dmem_size_i(size), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
      .dmem_rdy_o(rdy[1]), .dmem_vld_o(vld[1]), .dmem_rdata_o(rdata[1]), .dmem_err_o(err[1]));

   beta_dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT2), .BASE_ADDR(32'h0)) dut2 (
      .clk_i(clk), .rst_i(rst), .dmem_req_i(req[2]), .dmem_op_i(op),
      .dmem_size_i(size), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
      .dmem_rdy_o(rdy[2]), .dmem_vld_o(vld[2]), .dmem_rdata_o(rdata[2]), .dmem_err_o(err[2]));

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int latencyOf(input int idx);
      case (idx)
         0:       return LAT0;
         1:       return LAT1;
         default: return LAT2;
      endcase
   endfunction

   // Reference behaviour: memory is an array of bytes, an access covers
   // 1/2/4 consecutive bytes starting at addr, little-endian.
   task automatic modelAccess(input int idx, input logic o, input logic [1:0] s,
                              input logic [31:0] a, input logic [31:0] w,
                              output logic [31:0] expData, output logic expErr);
      int nb;
      nb      = (s == MEM_SIZE_WORD) ? 4 : (s == MEM_SIZE_HALF) ? 2 : 1;
      expErr  = (s == 2'b11) || ((int'(a[1:0]) % nb) != 0) || (a >= 32'(DEPTH*4));
      expData = '0;
      if (!expErr) begin
         for (int k = 0; k < nb; k++) begin
            if (o == MEM_STORE_OP) modelBytes[idx][int'(a) + k] = w[8*k +: 8];
            else                   expData[8*k +: 8] = modelBytes[idx][int'(a) + k];
         end
      end
   endtask

   // One full transaction on responder idx, starting and ending at a falling
   // edge with the responder idle.  Request fields are scrambled as soon as
   // rdy is seen, so the responder must be working from its latched copy.
   task automatic applyStimulus(input int idx, input logic o, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] w,
                                output logic [31:0] gotData, output logic gotErr,
                                output int rdyAt, output int vldAt,
                                output logic [31:0] expData, output logic expErr);
      modelAccess(idx, o, s, a, w, expData, expErr);
      op = o; size = s; addr = a; wdata = w;
      req[idx] = 1'b1;
      rdyAt = -1; vldAt = -1; gotData = '0; gotErr = 1'b0;
      for (int k = 1; k <= 40 && vldAt < 0; k++) begin
         @(negedge clk);
         if (rdy[idx] && rdyAt < 0) begin
            rdyAt    = k;
            req[idx] = 1'b0;
            op = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
         end
         if (vld[idx]) begin
            vldAt   = k;
            gotData = rdata[idx];
            gotErr  = err[idx];
         end
      end
      req[idx] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      req = '0; op = 1'b0; size = 2'b00; addr = '0; wdata = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NUM_DUT; i++) begin
         numCompared++;
         if (rdy[i] !== 1'b0 || vld[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0) begin
            numMismatched++;
            $display("[TB] FAIL reset_outputs dut%0d: rdy=%b vld=%b err=%b rdata=%h, want all 0",
                     i, rdy[i], vld[i], err[i], rdata[i]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Give the first 16 words of each RAM known contents.
   task automatic test_init_window();
      logic [31:0] got, expD; logic gotE, expE; int r, v;
      for (int i = 0; i < NUM_DUT; i++) begin
         for (int wd = 0; wd < 16; wd++) begin
            applyStimulus(i, MEM_STORE_OP, MEM_SIZE_WORD, 32'(wd*4), $urandom, got, gotE, r, v, expD, expE);
            numCompared++;
            if (gotE !== 1'b0 || v != latencyOf(i) + 2) begin
               numMismatched++;
               $display("[TB] FAIL init_store dut%0d word%0d: err=%b vldAt=%0d, want err=0 vldAt=%0d",
                        i, wd, gotE, v, latencyOf(i) + 2);
            end
         end
      end
   endtask

   task automatic test_store_load_word();
      logic [31:0] got, expD; logic gotE, expE; int r, v;
      applyStimulus(0, MEM_STORE_OP, MEM_SIZE_WORD, 32'h10, 32'hDEADBEEF, got, gotE, r, v, expD, expE);
      numCompared++;
      if (r != 1 || v != 3) begin
         numMismatched++;
         $display("[TB] FAIL store_timing: rdyAt=%0d vldAt=%0d, want 1 and 3", r, v);
      end
      numCompared++;
      if (gotE !== 1'b0 || got !== 32'h0) begin
         numMismatched++;
         $display("[TB] FAIL store_resp: err=%b rdata=%h, want 0/00000000", gotE, got);
      end
      applyStimulus(0, MEM_LOAD_OP, MEM_SIZE_WORD, 32'h10, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (got !== 32'hDEADBEEF || gotE !== 1'b0 || r != 1 || v != 3) begin
         numMismatched++;
         $display("[TB] FAIL load_word: rdata=%h err=%b rdyAt=%0d vldAt=%0d, want deadbeef 0 1 3",
                  got, gotE, r, v);
      end
   endtask

   task automatic test_byte_half();
      logic [31:0] got, expD; logic gotE, expE; int r, v;
      applyStimulus(0, MEM_STORE_OP, MEM_SIZE_BYTE, 32'h13, 32'h000000A5, got, gotE, r, v, expD, expE);
      applyStimulus(0, MEM_LOAD_OP, MEM_SIZE_WORD, 32'h10, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (got !== 32'hA5ADBEEF) begin
         numMismatched++;
         $display("[TB] FAIL byte_merge: rdata=%h, want a5adbeef", got);
      end
      applyStimulus(0, MEM_LOAD_OP, MEM_SIZE_HALF, 32'h12, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (got !== 32'h0000A5AD || gotE !== 1'b0) begin
         numMismatched++;
         $display("[TB] FAIL load_half_hi: rdata=%h err=%b, want 0000a5ad 0", got, gotE);
      end
   endtask

   task automatic test_errors();
      logic [31:0] got, expD; logic gotE, expE; int r, v;
      applyStimulus(0, MEM_LOAD_OP, MEM_SIZE_HALF, 32'h11, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (v != 3 || gotE !== 1'b1 || got !== 32'h0) begin
         numMismatched++;
         $display("[TB] FAIL misaligned_half_load: vldAt=%0d err=%b rdata=%h, want 3 1 0", v, gotE, got);
      end
      applyStimulus(0, MEM_STORE_OP, MEM_SIZE_WORD, 32'h11, 32'h11223344, got, gotE, r, v, expD, expE);
      numCompared++;
      if (gotE !== 1'b1) begin
         numMismatched++;
         $display("[TB] FAIL misaligned_word_store: err=%b, want 1", gotE);
      end
      applyStimulus(0, MEM_STORE_OP, MEM_SIZE_WORD, 32'(DEPTH*4), 32'h55667788, got, gotE, r, v, expD, expE);
      numCompared++;
      if (gotE !== 1'b1) begin
         numMismatched++;
         $display("[TB] FAIL range_store: err=%b, want 1", gotE);
      end
      applyStimulus(0, MEM_LOAD_OP, MEM_SIZE_WORD, 32'(DEPTH*4), 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (gotE !== 1'b1 || got !== 32'h0) begin
         numMismatched++;
         $display("[TB] FAIL range_load: err=%b rdata=%h, want 1 0", gotE, got);
      end
      applyStimulus(0, MEM_STORE_OP, 2'b11, 32'h10, 32'h99999999, got, gotE, r, v, expD, expE);
      numCompared++;
      if (gotE !== 1'b1) begin
         numMismatched++;
         $display("[TB] FAIL illegal_size: err=%b, want 1", gotE);
      end
      applyStimulus(0, MEM_LOAD_OP, MEM_SIZE_WORD, 32'h10, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (got !== 32'hA5ADBEEF) begin
         numMismatched++;
         $display("[TB] FAIL word10_untouched: rdata=%h, want a5adbeef", got);
      end
      applyStimulus(0, MEM_LOAD_OP, MEM_SIZE_WORD, 32'h0, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (got !== expD) begin
         numMismatched++;
         $display("[TB] FAIL word0_untouched: rdata=%h, want %h", got, expD);
      end
   endtask

   task automatic test_latency();
      logic [31:0] got, expD; logic gotE, expE; int r, v;
      for (int i = 1; i < NUM_DUT; i++) begin
         applyStimulus(i, MEM_STORE_OP, MEM_SIZE_HALF, 32'h1E, 32'h0000BEAD, got, gotE, r, v, expD, expE);
         applyStimulus(i, MEM_LOAD_OP, MEM_SIZE_WORD, 32'h1C, 32'h0, got, gotE, r, v, expD, expE);
         numCompared++;
         if (r != 1 || v != latencyOf(i) + 2 || got !== expD || gotE !== 1'b0) begin
            numMismatched++;
            $display("[TB] FAIL latency dut%0d: rdyAt=%0d vldAt=%0d rdata=%h, want 1 %0d %h",
                     i, r, v, got, latencyOf(i) + 2, expD);
         end
      end
   endtask

   task automatic test_back_to_back();
      int rdyTimes[$];
      for (int i = 0; i < NUM_DUT; i++) begin
         rdyTimes.delete();
         op = MEM_LOAD_OP; size = MEM_SIZE_WORD; addr = 32'h10; wdata = '0;
         req[i] = 1'b1;
         for (int k = 1; k <= 120 && rdyTimes.size() < 3; k++) begin
            @(negedge clk);
            if (rdy[i]) rdyTimes.push_back(k);
         end
         req[i] = 1'b0;
         numCompared++;
         if (rdyTimes.size() != 3) begin
            numMismatched++;
            $display("[TB] FAIL b2b_count dut%0d: saw %0d rdy pulses, want 3", i, rdyTimes.size());
         end else begin
            for (int j = 1; j < 3; j++) begin
               numCompared++;
               if (rdyTimes[j] - rdyTimes[j-1] != latencyOf(i) + 3) begin
                  numMismatched++;
                  $display("[TB] FAIL b2b_spacing dut%0d: rdy gap %0d, want %0d",
                           i, rdyTimes[j] - rdyTimes[j-1], latencyOf(i) + 3);
               end
            end
         end
         repeat (latencyOf(i) + 4) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] got, expD; logic gotE, expE; int r, v; int rdyAt; int sawVld;
      // Reset during the wait phase of a store: the write has already landed.
      op = MEM_STORE_OP; size = MEM_SIZE_WORD; addr = 32'h20; wdata = 32'h12345678;
      req[2] = 1'b1;
      rdyAt = -1;
      for (int k = 1; k <= 5 && rdyAt < 0; k++) begin
         @(negedge clk);
         if (rdy[2]) rdyAt = k;
      end
      req[2] = 1'b0;
      modelAccess(2, MEM_STORE_OP, MEM_SIZE_WORD, 32'h20, 32'h12345678, expD, expE);
      numCompared++;
      if (rdyAt != 1) begin
         numMismatched++;
         $display("[TB] FAIL rst_wait_rdy: rdyAt=%0d, want 1", rdyAt);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      numCompared++;
      if (rdy[2] !== 1'b0 || vld[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 32'h0) begin
         numMismatched++;
         $display("[TB] FAIL rst_wait_outputs: rdy=%b vld=%b err=%b rdata=%h, want all 0",
                  rdy[2], vld[2], err[2], rdata[2]);
      end
      @(negedge clk);
      rst = 1'b0;
      sawVld = 0;
      repeat (20) begin
         @(negedge clk);
         if (vld[2]) sawVld++;
      end
      numCompared++;
      if (sawVld != 0) begin
         numMismatched++;
         $display("[TB] FAIL rst_wait_novld: saw %0d vld pulses, want 0", sawVld);
      end
      applyStimulus(2, MEM_LOAD_OP, MEM_SIZE_WORD, 32'h20, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (got !== 32'h12345678) begin
         numMismatched++;
         $display("[TB] FAIL rst_wait_written: rdata=%h, want 12345678", got);
      end

      // Reset during ACK of a store: nothing may be written.
      op = MEM_STORE_OP; size = MEM_SIZE_WORD; addr = 32'h24; wdata = 32'hCAFEF00D;
      req[2] = 1'b1;
      @(negedge clk);
      req[2] = 1'b0;
      numCompared++;
      if (rdy[2] !== 1'b1) begin
         numMismatched++;
         $display("[TB] FAIL rst_ack_rdy: rdy=%b, want 1", rdy[2]);
      end
      rst = 1'b1;
      #1;
      numCompared++;
      if (rdy[2] !== 1'b0) begin
         numMismatched++;
         $display("[TB] FAIL rst_ack_drop: rdy=%b, want 0", rdy[2]);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(2, MEM_LOAD_OP, MEM_SIZE_WORD, 32'h24, 32'h0, got, gotE, r, v, expD, expE);
      numCompared++;
      if (got !== expD) begin
         numMismatched++;
         $display("[TB] FAIL rst_ack_nowrite: rdata=%h, want %h", got, expD);
      end
   endtask

   task automatic test_random(input int idx, input int count);
      logic [31:0] got, expD, a; logic gotE, expE; int r, v, pick; logic o; logic [1:0] s;
      for (int n = 0; n < count; n++) begin
         o    = 1'($urandom_range(0, 1));
         pick = int'($urandom_range(0, 9));
         s    = (pick < 3) ? MEM_SIZE_WORD : (pick < 6) ? MEM_SIZE_HALF : (pick < 9) ? MEM_SIZE_BYTE : 2'b11;
         if ($urandom_range(0, 7) == 0) a = 32'(DEPTH*4) + $urandom_range(0, 255);
         else                           a = $urandom_range(0, 63);
         applyStimulus(idx, o, s, a, $urandom, got, gotE, r, v, expD, expE);
         numCompared++;
         if (got !== expD || gotE !== expE) begin
            numMismatched++;
            $display("[TB] FAIL random dut%0d op=%b size=%0d addr=%h: rdata=%h err=%b, want %h %b",
                     idx, o, s, a, got, gotE, expD, expE);
         end
         numCompared++;
         if (r != 1 || v != latencyOf(idx) + 2) begin
            numMismatched++;
            $display("[TB] FAIL random_timing dut%0d: rdyAt=%0d vldAt=%0d, want 1 %0d",
                     idx, r, v, latencyOf(idx) + 2);
         end
      end
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      test_reset();
      test_init_window();
      test_store_load_word();
      test_byte_half();
      test_errors();
      test_latency();
      test_back_to_back();
      test_reset_mid();
      test_random(0, 60);
      test_random(1, 30);
      test_random(2, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
